// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: RV64 load/store funct3
// encodings and the access FSM state type.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mem_state_t;

    // Byte-lane mask for an access of the size encoded in funct3[1:0].
    function automatic logic [7:0] size_mask(input logic [1:0] size_code);
        logic [7:0] mask;
        case (size_code)
            2'b00:   mask = 8'h01;
            2'b01:   mask = 8'h03;
            2'b10:   mask = 8'h0F;
            2'b11:   mask = 8'hFF;
            default: mask = 8'h00;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/load_extender.sv
// Combinational load formatter: selects the addressed bytes out of an aligned
// doubleword and sign- or zero-extends them to 64 bits.
module load_extender
    import mem_pkg::*;
(
    input  logic [63:0] raw_bytes,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] ext_data
);

    logic [63:0] shifted_s;

    // Align the addressed byte to lane 0, then extend by access type.
    always_comb begin
        shifted_s = raw_bytes >> {offset, 3'b000};
        case (funct3)
            F3_B:    ext_data = {{56{shifted_s[7]}},  shifted_s[7:0]};
            F3_H:    ext_data = {{48{shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    ext_data = {{32{shifted_s[31]}}, shifted_s[31:0]};
            F3_D:    ext_data = shifted_s;
            F3_BU:   ext_data = {56'd0, shifted_s[7:0]};
            F3_HU:   ext_data = {48'd0, shifted_s[15:0]};
            F3_WU:   ext_data = {32'd0, shifted_s[31:0]};
            default: ext_data = 64'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_stage.sv
// MEM stage of the 5-stage RV64 pipeline: byte-addressable data memory with a
// programmable access latency, pipeline stall and fault reporting.
module data_mem_stage
    import mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [63:0] ALU_result,
    input  logic [63:0] WriteData,
    output logic [63:0] ReadData,
    output logic        stall,
    output logic        mem_fault
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = $clog2(LATENCY + 1);
    localparam logic [63:0]     DEPTH_W = 64'(DEPTH);
    localparam logic [CW-1:0]   LAT_W   = CW'(LATENCY);
    localparam logic [CW-1:0]   ONE_W   = CW'(1);

    mem_state_t     state_r;
    logic [CW-1:0]  cnt_r;
    logic [7:0]     mem_r [DEPTH];

    logic           req_s;
    logic           misalign_s;
    logic           f3_ok_s;
    logic           range_ok_s;
    logic           access_ok_s;
    logic           commit_s;
    logic [2:0]     offset_s;
    logic [AW-1:0]  base_s;
    logic [7:0]     byte_en_s;
    logic [63:0]    wdata_sh_s;
    logic [63:0]    raw_s;
    logic [63:0]    ext_s;

    // Access legality: alignment, range and funct3 (store rules win when both strobes are set).
    always_comb begin
        req_s = MemRead | MemWrite;
        case (funct3[1:0])
            2'b00:   misalign_s = 1'b0;
            2'b01:   misalign_s = ALU_result[0];
            2'b10:   misalign_s = |ALU_result[1:0];
            2'b11:   misalign_s = |ALU_result[2:0];
            default: misalign_s = 1'b1;
        endcase
        if (MemWrite) begin
            f3_ok_s = (funct3[2] == 1'b0);
        end else begin
            f3_ok_s = (funct3 != 3'b111);
        end
        range_ok_s  = (ALU_result < DEPTH_W);
        access_ok_s = f3_ok_s && range_ok_s && !misalign_s;
    end

    // Stall and fault are combinational so the pipeline freezes in the request cycle itself.
    always_comb begin
        stall     = rst_n && ((state_r == ST_BUSY) ||
                              ((state_r == ST_IDLE) && req_s && access_ok_s));
        mem_fault = rst_n && (state_r == ST_IDLE) && req_s && !access_ok_s;
        commit_s  = (state_r == ST_BUSY) && (cnt_r == ONE_W);
    end

    // Doubleword-aligned view of the memory around the current address.
    always_comb begin
        offset_s   = ALU_result[2:0];
        base_s     = {ALU_result[AW-1:3], 3'b000};
        byte_en_s  = size_mask(funct3[1:0]) << offset_s;
        wdata_sh_s = WriteData << {offset_s, 3'b000};
        raw_s      = 64'd0;
        for (int i = 0; i < 8; i++) begin
            raw_s[8*i +: 8] = mem_r[base_s + AW'(i)];
        end
    end

    load_extender u_load_extender (
        .raw_bytes (raw_s),
        .offset    (offset_s),
        .funct3    (funct3),
        .ext_data  (ext_s)
    );

    // Store commit on the last BUSY edge; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (commit_s && MemWrite) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en_s[i]) begin
                    mem_r[base_s + AW'(i)] <= wdata_sh_s[8*i +: 8];
                end
            end
        end
    end

    // Access FSM with latency counter and registered load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            ReadData <= 64'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        if (access_ok_s) begin
                            state_r <= ST_BUSY;
                            cnt_r   <= LAT_W;
                        end else begin
                            ReadData <= 64'd0;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt_r <= cnt_r - ONE_W;
                    if (cnt_r == ONE_W) begin
                        state_r <= ST_DONE;
                        if (MemWrite && MemRead) begin
                            ReadData <= 64'd0;
                        end else if (MemRead) begin
                            ReadData <= ext_s;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule
